// File: rtl/mips_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/gnt/rvalid handshake
// with one request outstanding, and fills the IF/ID slot consumed by decode.
module mips_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] if_instr,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        discard_q, discard_d;
    logic        slot_valid_q, slot_valid_d;
    logic [31:0] slot_pc_q, slot_pc_d;
    logic [31:0] slot_pc4_q, slot_pc4_d;
    logic [31:0] slot_instr_q, slot_instr_d;
    logic [31:0] count_q, count_d;
    logic        load;
    logic        unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        discard_d    = discard_q;
        slot_valid_d = slot_valid_q;
        slot_pc_d    = slot_pc_q;
        slot_pc4_d   = slot_pc4_q;
        slot_instr_d = slot_instr_q;
        count_d      = count_q;
        imem_req     = 1'b0;
        imem_addr    = pc_q;
        load         = 1'b0;

        // Decode takes the slot this cycle; a same-cycle load below overrides.
        if (slot_valid_q && !stall) begin
            slot_valid_d = 1'b0;
            slot_instr_d = NOP_INSTR;
        end

        unique case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                imem_req = !(slot_valid_q && stall);
                if (imem_req && imem_gnt) begin
                    state_d   = StWait;
                    // Old-PC request is now in flight; its word must be dropped.
                    discard_d = redirect_valid;
                end
            end
            StWait: begin
                if (imem_rvalid) begin
                    state_d   = StReq;
                    discard_d = 1'b0;
                    load      = !discard_q && !redirect_valid;
                end else if (redirect_valid) begin
                    discard_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            slot_valid_d = 1'b1;
            slot_pc_d    = pc_q;
            slot_pc4_d   = pc_q + 32'd4;
            slot_instr_d = imem_rdata;
            pc_d         = pc_q + 32'd4;
            count_d      = count_q + 32'd1;
        end

        if (redirect_valid) begin
            pc_d         = {redirect_pc[31:2], 2'b00};
            slot_valid_d = 1'b0;
            slot_instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            discard_q    <= 1'b0;
            slot_valid_q <= 1'b0;
            slot_pc_q    <= 32'h0;
            slot_pc4_q   <= 32'h0;
            slot_instr_q <= NOP_INSTR;
            count_q      <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            discard_q    <= discard_d;
            slot_valid_q <= slot_valid_d;
            slot_pc_q    <= slot_pc_d;
            slot_pc4_q   <= slot_pc4_d;
            slot_instr_q <= slot_instr_d;
            count_q      <= count_d;
        end
    end

    assign if_valid    = slot_valid_q;
    assign if_pc       = slot_pc_q;
    assign if_pc_plus4 = slot_pc4_q;
    assign if_instr    = slot_instr_q;
    assign fetch_count = count_q;

endmodule

// File: doc/mips_fetch_stage.md
Name: mips_fetch_stage

Overview:
- Instruction-fetch stage for the 32-bit MIPS core: owns the PC and issues requests to instruction memory over a request/grant/response handshake.
- Loads each returned word into the IF/ID pipeline register consumed by decode.
- Handles decode back-pressure (stall) and branch/jump redirects, including discarding in-flight fetches.
- Sits between the core's instruction memory and the decode stage, inside the MIPS top driven by the system clock.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0000, value driven on if_instr whenever the slot is invalid or flushed.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- stall  input  1  decode cannot accept; hold the IF/ID slot
- redirect_valid  input  1  branch/jump taken this cycle
- redirect_pc  input  32  target PC; bits [1:0] ignored and treated as 0
- imem_req  output  1  fetch request valid
- imem_addr  output  32  word-aligned fetch address
- imem_gnt  input  1  memory accepts the request this cycle
- imem_rvalid  input  1  response word valid (one or more cycles after gnt)
- imem_rdata  input  32  fetched instruction
- if_valid  output  1  IF/ID slot holds a valid instruction
- if_pc  output  32  PC of the instruction in the slot
- if_pc_plus4  output  32  if_pc + 4, modulo 2^32
- if_instr  output  32  instruction in the slot
- fetch_count  output  32  number of instructions delivered to the slot, wraps

Behaviour:
- Clock and reset: one clock; synchronous active-high reset, sampled on rising clk.
- Reset values:
  - State = IDLE, pc = RESET_PC, discard = 0.
  - imem_req = 0, imem_addr = RESET_PC.
  - if_valid = 0, if_pc = 0, if_pc_plus4 = 0, if_instr = NOP_INSTR.
  - fetch_count = 0.
- Reset mid-operation:
  - Aborts any outstanding fetch; instruction memory is reset by the same rst.
  - imem_rvalid is ignored in IDLE and REQ.
- Slot consumption: decode consumes the slot on any cycle with if_valid=1 and stall=0. If nothing new loads that cycle, if_valid <= 0.
- Single outstanding request only.
- FSM:
  - IDLE: exactly one cycle after reset deasserts, then go to REQ.
  - REQ:
    - imem_req = !(if_valid && stall); imem_addr = pc.
    - On imem_req && imem_gnt, go to WAIT.
  - WAIT:
    - imem_req = 0.
    - On imem_rvalid with discard=0: slot <= {1, pc, pc+4, imem_rdata}; pc <= pc+4; fetch_count++; go to REQ.
    - On imem_rvalid with discard=1: drop the word, clear discard, go to REQ; pc is unchanged and already holds the target.
- Slot overwrite: a new load cannot collide with a stalled slot, because a request is only issued when the slot is empty or being consumed that cycle.
- Best-case throughput: gnt in REQ plus rvalid one cycle later gives one instruction every 2 cycles.
- Redirect (highest priority after rst), on redirect_valid=1:
  - pc <= {redirect_pc[31:2], 2'b00}.
  - if_valid <= 0 and if_instr <= NOP_INSTR, regardless of stall.
  - Any response arriving the same cycle is dropped.
  - In WAIT without same-cycle rvalid: set discard=1.
  - In REQ with same-cycle gnt: go to WAIT with discard=1 (the old-PC request is in flight).
  - In REQ without gnt: stay in REQ; the next request uses the new pc.
  - A second redirect while discard=1 only updates pc; discard stays 1.
- Stall: while if_valid && stall, the slot and fetch_count are frozen and no request is issued.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.

Test Plan:
- Reset then run with gnt=1 always and rvalid 1 cycle after gnt, words A0,A1,A2 -> if_pc 0,4,8 with matching if_instr, if_valid pulses every 2 cycles, fetch_count = 3.
- Assert stall while slot holds pc=4 for 5 cycles -> imem_req=0, if_pc stays 4, fetch_count unchanged; release stall -> next request at addr 8.
- Redirect to 32'h0000_0102 while in WAIT for addr 8 -> if_valid drops next cycle; the returned word for 8 is discarded; next request at 32'h0000_0100, and the slot then shows pc 0x100.
- Redirect in the same cycle as gnt for addr 0x10, target 0x40 -> the response is discarded; next imem_addr = 0x40; fetch_count does not count 0x10.
- Assert rst mid-WAIT -> next cycle all outputs at reset values, IDLE for one cycle, then first request at RESET_PC.
- Redirect to 32'hFFFF_FFFC and fetch twice -> if_pc 0xFFFF_FFFC then 0x0000_0000; if_pc_plus4 = 0 on the first.
